// File: rtl/code2421_pkg.sv
// Shared 2421 code constants, tracker state enum and 2421<->BCD conversions.
package code2421_pkg;

  typedef enum logic [1:0] {SYNC, TRACK, LOCKED} state_t;

  localparam logic [3:0] C2421_0 = 4'b0000;
  localparam logic [3:0] C2421_1 = 4'b0001;
  localparam logic [3:0] C2421_2 = 4'b0010;
  localparam logic [3:0] C2421_3 = 4'b0011;
  localparam logic [3:0] C2421_4 = 4'b0100;
  localparam logic [3:0] C2421_5 = 4'b1011;
  localparam logic [3:0] C2421_6 = 4'b1100;
  localparam logic [3:0] C2421_7 = 4'b1101;
  localparam logic [3:0] C2421_8 = 4'b1110;
  localparam logic [3:0] C2421_9 = 4'b1111;

  function automatic logic [3:0] bcd_to_2421(input logic [3:0] d);
    case (d)
      4'd0:    return C2421_0;
      4'd1:    return C2421_1;
      4'd2:    return C2421_2;
      4'd3:    return C2421_3;
      4'd4:    return C2421_4;
      4'd5:    return C2421_5;
      4'd6:    return C2421_6;
      4'd7:    return C2421_7;
      4'd8:    return C2421_8;
      4'd9:    return C2421_9;
      default: return C2421_0;
    endcase
  endfunction

  // Returns {bad, bcd}; bad is set for the six unused codes.
  function automatic logic [4:0] c2421_decode(input logic [3:0] c);
    case (c)
      C2421_0: return {1'b0, 4'd0};
      C2421_1: return {1'b0, 4'd1};
      C2421_2: return {1'b0, 4'd2};
      C2421_3: return {1'b0, 4'd3};
      C2421_4: return {1'b0, 4'd4};
      C2421_5: return {1'b0, 4'd5};
      C2421_6: return {1'b0, 4'd6};
      C2421_7: return {1'b0, 4'd7};
      C2421_8: return {1'b0, 4'd8};
      C2421_9: return {1'b0, 4'd9};
      default: return {1'b1, 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/code2421_to_bcd.sv
// Combinational 2421 -> 8421 BCD decode with an illegal-code flag.
module code2421_to_bcd
  import code2421_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       bad
);

  always_comb begin
    {bad, bcd} = c2421_decode(code);
  end

endmodule

// File: rtl/code2421_decade_tracker.sv
// Tracks a 2421 units counter, locks onto clean +1 stepping and counts tens.
// Optional err_cnt output enabled by macro CODE2421_ERRCNT_EN.
module code2421_decade_tracker
  import code2421_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code_in,
  input  logic       code_valid,
  output logic [3:0] digit_bcd,
  output logic [3:0] tens_bcd,
  output logic [3:0] tens_2421,
  output logic       locked,
  output logic       carry_out,
  output logic       illegal,
  output logic       seq_err
`ifdef CODE2421_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  state_t     state, state_nxt;
  logic [2:0] run, run_nxt, run_inc;
  logic [3:0] prev, prev_nxt;
  logic [3:0] tens_nxt, want;
  logic [3:0] dec_bcd;
  logic       dec_bad, step_ok, legal_smp;
  logic       illegal_nxt, seq_err_nxt, carry_nxt;

  code2421_to_bcd u_dec (
    .code (code_in),
    .bcd  (dec_bcd),
    .bad  (dec_bad)
  );

  assign want      = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
  assign step_ok   = (dec_bcd == want);
  assign run_inc   = run + 3'd1;
  assign legal_smp = code_valid && !dec_bad;
  assign digit_bcd = prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      run       <= '0;
      prev      <= '0;
      tens_bcd  <= '0;
      tens_2421 <= C2421_0;
      locked    <= 1'b0;
      carry_out <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      prev      <= prev_nxt;
      tens_bcd  <= tens_nxt;
      tens_2421 <= bcd_to_2421(tens_nxt);
      locked    <= (state_nxt == LOCKED);
      carry_out <= carry_nxt;
      illegal   <= illegal_nxt;
      seq_err   <= seq_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    prev_nxt  = prev;
    tens_nxt  = tens_bcd;
    if (code_valid && dec_bad) begin
      state_nxt = SYNC;
      run_nxt   = '0;
    end else if (legal_smp) begin
      prev_nxt = dec_bcd;
      case (state)
        SYNC: begin
          run_nxt   = '0;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (step_ok) begin
            run_nxt = run_inc;
            if (run_inc == 3'(LOCK_COUNT)) state_nxt = LOCKED;
          end else begin
            run_nxt = '0;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            if (prev == 4'd9) tens_nxt = (tens_bcd == 4'd9) ? 4'd0 : tens_bcd + 4'd1;
          end else begin
            run_nxt   = '0;
            state_nxt = TRACK;
          end
        end
        default: begin
          run_nxt   = '0;
          state_nxt = SYNC;
        end
      endcase
    end
  end

  always_comb begin
    illegal_nxt = code_valid && dec_bad;
    seq_err_nxt = legal_smp && (state == LOCKED) && !step_ok;
    carry_nxt   = legal_smp && (state == LOCKED) && step_ok &&
                  (prev == 4'd9) && (tens_bcd == 4'd9);
  end

`ifdef CODE2421_ERRCNT_EN
  // Counts alongside the pulse it records, so it agrees with the pulse cycle.
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if ((illegal_nxt || seq_err_nxt) && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_code2421_decade_tracker.sv
// Randomized + directed bench for code2421_decade_tracker against an integer reference model.
module tb_code2421_decade_tracker;

  localparam int LC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = 4'd0;
  logic       code_valid = 1'b0;
  logic [3:0] digit_bcd, tens_bcd, tens_2421;
  logic       locked, carry_out, illegal, seq_err;
`ifdef CODE2421_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  code2421_decade_tracker #(.LOCK_COUNT(LC)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .digit_bcd  (digit_bcd),
    .tens_bcd   (tens_bcd),
    .tens_2421  (tens_2421),
    .locked     (locked),
    .carry_out  (carry_out),
    .illegal    (illegal),
    .seq_err    (seq_err)
`ifdef CODE2421_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: plain integers following the tracking rules.
  int m_prev, m_tens, m_streak, m_errc;
  bit m_synced, m_lock, m_carry, m_ill, m_seq;
  int code_tab [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [3:0] enc(input int d);
    logic [3:0] r;
    r = 4'(code_tab[d]);
    return r;
  endfunction

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 10; i++) if (code_tab[i] == int'(c)) return i;
    return -1;
  endfunction

  task automatic model(input bit r, input bit v, input logic [3:0] c);
    int d;
    m_carry = 0; m_ill = 0; m_seq = 0;
    if (r) begin
      m_prev = 0; m_tens = 0; m_streak = 0; m_errc = 0;
      m_synced = 0; m_lock = 0;
      return;
    end
    if (!v) return;
    d = lookup(c);
    if (d < 0) begin
      m_ill = 1; m_synced = 0; m_lock = 0; m_streak = 0;
    end else begin
      if (!m_synced) begin
        m_synced = 1; m_streak = 0;
      end else if (m_lock) begin
        if (d == (m_prev + 1) % 10) begin
          if (m_prev == 9) begin
            m_tens = (m_tens + 1) % 10;
            m_carry = (m_tens == 0);
          end
        end else begin
          m_seq = 1; m_lock = 0; m_streak = 0;
        end
      end else begin
        if (d == (m_prev + 1) % 10) begin
          m_streak++;
          if (m_streak == LC) m_lock = 1;
        end else m_streak = 0;
      end
      m_prev = d;
    end
    if ((m_ill || m_seq) && m_errc < 255) m_errc++;
  endtask

  task automatic compare_all();
    chk("digit_bcd", digit_bcd, m_prev);
    chk("tens_bcd", tens_bcd, m_tens);
    chk("tens_2421", tens_2421, code_tab[m_tens]);
    chk("locked", locked, m_lock);
    chk("carry_out", carry_out, m_carry);
    chk("illegal", illegal, m_ill);
    chk("seq_err", seq_err, m_seq);
`ifdef CODE2421_ERRCNT_EN
    chk("err_cnt", err_cnt, m_errc);
`endif
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] c);
    rst = r; code_valid = v; code_in = c;
    @(posedge clk);
    model(r, v, c);
    #1;
    compare_all();
  endtask

  task automatic feed(input int d);
    step(1'b0, 1'b1, enc(d));
  endtask

  initial begin
    int guard;
    logic [3:0] c;
    model(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'b0101);
    step(1'b1, 1'b0, 4'd0);
    chk("reset_locked", locked, 0);
    chk("reset_tens_2421", tens_2421, 0);

    // lock on 0,1,2
    feed(0); feed(1); feed(2);
    chk("lock_after_012", locked, 1);
    chk("digit_after_012", digit_bcd, 2);
    for (int d = 3; d <= 9; d++) feed(d);
    feed(0);
    chk("tens_first_wrap", tens_bcd, 1);
    chk("tens2421_first_wrap", tens_2421, 4'b0001);
    chk("no_carry_first_wrap", carry_out, 0);

    // run up to tens=9, prev=9, then wrap
    guard = 0;
    while (!(m_tens == 9 && m_prev == 9) && guard < 200) begin
      feed((m_prev + 1) % 10);
      guard++;
    end
    chk("reach_tens9_bound", int'(guard < 200), 1);
    feed(0);
    chk("carry_pulse", carry_out, 1);
    chk("tens_wrap_zero", tens_bcd, 0);
    feed(1);
    chk("carry_one_cycle", carry_out, 0);

    // illegal at 3, then relock at 6
    feed(2); feed(3);
    step(1'b0, 1'b1, 4'b0101);
    chk("illegal_pulse", illegal, 1);
    chk("illegal_unlock", locked, 0);
    chk("illegal_digit_hold", digit_bcd, 3);
    step(1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1100);
    chk("relock", locked, 1);
    chk("relock_digit", digit_bcd, 6);

    // seq_err: locked at 4, then 6
    step(1'b1, 1'b0, 4'd0);
    for (int d = 0; d <= 4; d++) feed(d);
    step(1'b0, 1'b1, 4'b1100);
    chk("seq_err_pulse", seq_err, 1);
    chk("seq_err_unlock", locked, 0);

    // repeated value while locked is a sequence break
    feed(7); feed(8);
    feed(8);
    chk("repeat_seq_err", seq_err, 1);

    // valid gaps through a count, then reset at tens=5
    step(1'b1, 1'b0, 4'd0);
    guard = 0;
    while (!(m_tens == 5 && m_lock) && guard < 400) begin
      feed((m_prev + 1) % 10);
      step(1'b0, 1'b0, 4'b0101);
      guard++;
    end
    chk("reach_tens5_bound", int'(guard < 400), 1);
    step(1'b1, 1'b1, enc((m_prev + 1) % 10));
    chk("rst_tens", tens_bcd, 0);
    chk("rst_locked", locked, 0);
    chk("rst_digit", digit_bcd, 0);

    // random soak: mostly good steps, some illegal/wrong codes, gaps, rare resets
    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      c = enc((m_prev + 1) % 10);
      else if (sel < 80) c = 4'($urandom_range(5, 10));
      else               c = enc(int'($urandom_range(0, 9)));
      step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 85), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/code2421_decade_tracker.md
CODE2421_DECADE_TRACKER -- requirements
Module: code2421_decade_tracker

Interface
REQ-001 Parameter LOCK_COUNT, default 2: number of consecutive correct +1 steps needed to reach LOCKED (legal range 1..7).
REQ-002 clk  input  1  single clock; all logic updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 code_in  input  4  2421-coded units digit from the upstream 2421 counter.
REQ-005 code_valid  input  1  code_in is sampled only on clock edges where this is 1.
REQ-006 digit_bcd  output  4  last legal units digit, 8421 BCD.
REQ-007 tens_bcd  output  4  tens digit, 8421 BCD, 0..9.
REQ-008 tens_2421  output  4  tens digit, 2421 code, always the encoding of tens_bcd.
REQ-009 locked  output  1  1 while state is LOCKED.
REQ-010 carry_out  output  1  one-cycle pulse when tens wraps 9->0.
REQ-011 illegal  output  1  one-cycle pulse on a sampled illegal code.
REQ-012 seq_err  output  1  one-cycle pulse on a sequence break while LOCKED.

Function
REQ-013 Legal 2421 map SHALL be: 0000=0, 0001=1, 0010=2, 0011=3, 0100=4, 1011=5, 1100=6, 1101=7, 1110=8, 1111=9; all other six codes are illegal.
REQ-014 All outputs SHALL be registered; response to a sample appears one cycle after the sampling edge.
REQ-015 If code_valid=0, all state and outputs SHALL hold, and pulse outputs SHALL be 0.
REQ-016 State machine SHALL have states SYNC, TRACK and LOCKED; an internal register prev holds the last legal digit, and run (3 bits) counts good steps.
REQ-017 Illegal sample, any state: illegal=1, next state SYNC, run=0; prev, digit_bcd and tens SHALL hold.
REQ-018 SYNC, legal sample d: prev=d, digit_bcd=d, run=0, next state TRACK.
REQ-019 TRACK, legal d equal to (prev+1) mod 10: run+1; if run+1==LOCK_COUNT, next state LOCKED, else stay in TRACK.
REQ-020 TRACK, legal d not equal to (prev+1) mod 10: run=0, stay in TRACK, no seq_err.
REQ-021 LOCKED, legal d equal to (prev+1) mod 10: stay in LOCKED; if prev=9 and d=0, tens increments mod 10, and carry_out=1 when tens goes 9->0.
REQ-022 LOCKED, legal d not equal to (prev+1) mod 10, including a repeated value: seq_err=1, run=0, next state TRACK, tens held.
REQ-023 Tens SHALL increment only in LOCKED; a 9->0 step seen in TRACK does not increment tens.
REQ-024 In every state, every legal sample SHALL update prev and digit_bcd to d.

Reset
REQ-025 rst=1 SHALL take priority over code_valid, with these results on the next edge:
- state SYNC, prev=0, run=0
- digit_bcd=0, tens_bcd=0, tens_2421=0000
- locked=0, carry_out=0, illegal=0, seq_err=0
REQ-026 Reset asserted mid-sequence SHALL discard lock and tens with no pulse output.

Configuration
REQ-027 Macro CODE2421_ERRCNT_EN, when defined:
- adds output err_cnt [7:0]
- err_cnt increments on each illegal or seq_err pulse and saturates at 255
- err_cnt clears on rst
REQ-028 When CODE2421_ERRCNT_EN is undefined, the port and counter SHALL be absent, and all other behaviour is identical.

Structure
REQ-029 Shared package code2421_pkg SHALL hold:
- the ten legal 2421 code constants
- the state enum (SYNC/TRACK/LOCKED)
- the 2421<->BCD conversion functions
REQ-030 One sub-module, code2421_to_bcd (combinational decode to a 4-bit BCD value plus an illegal flag), SHALL be instantiated once on code_in; the tens 2421 encode uses the package function.

Verification
REQ-031 Reset, then codes 0,1,2 (2421: 0000,0001,0010) with valid=1 -> locked=1 one cycle after the third sample; digit_bcd=2; tens_bcd=0.
REQ-032 Locked; run 2421 stream 7,8,9,0 (1101,1110,1111,0000) -> tens_bcd 0->1, tens_2421=0001, carry_out=0.
REQ-033 Locked with tens=9; step 9->0 -> tens_bcd=0, tens_2421=0000, carry_out=1 for exactly one cycle.
REQ-034 Locked at 3; inject 0101 -> illegal=1 for one cycle, locked=0, digit_bcd stays 3; then 0100,1011,1100 -> relock and digit_bcd=6.
REQ-035 Locked at 4; next code 1100 (6) -> seq_err=1, locked=0, tens held; and with CODE2421_ERRCNT_EN defined, err_cnt=1.
REQ-036 valid toggled 1/0 through a count, then rst asserted while locked with tens=5 -> gaps cause no change and no pulses; after reset all outputs are 0 and state is SYNC.
